// File: rtl/video_layer_compositor_if.sv
// Pixel-stream bundle shared by the layer generators, the compositor and the HDMI encoder.
// The compositor takes the slave side; the generator/encoder side takes master.
interface video_layer_compositor_if #(
  parameter int NUM_LAYERS = 4,
  parameter int COORDSPC   = 16,
  parameter int COLSPC     = 10
);
  logic                         video_enable;
  logic                         vsync;
  logic                         hsync;
  logic                         frame_start;
  logic                         line_start;
  logic [COORDSPC-1:0]          sx;
  logic [COORDSPC-1:0]          sy;
  logic [NUM_LAYERS*COLSPC-1:0] layer_red;
  logic [NUM_LAYERS*COLSPC-1:0] layer_green;
  logic [NUM_LAYERS*COLSPC-1:0] layer_blue;
  logic [NUM_LAYERS-1:0]        layer_en;
  logic [NUM_LAYERS-1:0]        layer_blend;
  logic [COLSPC-1:0]            red;
  logic [COLSPC-1:0]            green;
  logic [COLSPC-1:0]            blue;
  logic                         out_de;
  logic                         out_vsync;
  logic                         out_hsync;
  logic                         out_frame_start;
  logic                         out_line_start;

  modport master (
    output video_enable, vsync, hsync, frame_start, line_start, sx, sy,
           layer_red, layer_green, layer_blue, layer_en, layer_blend,
    input  red, green, blue, out_de, out_vsync, out_hsync, out_frame_start, out_line_start
  );

  modport slave (
    input  video_enable, vsync, hsync, frame_start, line_start, sx, sy,
           layer_red, layer_green, layer_blue, layer_en, layer_blend,
    output red, green, blue, out_de, out_vsync, out_hsync, out_frame_start, out_line_start
  );
endinterface

// File: rtl/video_layer_compositor.sv
// N-layer keyed pixel compositor, bottom-up registered pipeline with LAT = NUM_LAYERS.
// Optional 50% blend per layer is enabled by defining VIDEO_COMPOSITOR_BLEND_EN.
module video_layer_compositor #(
  parameter int                  NUM_LAYERS = 4,
  parameter int                  COORDSPC   = 16,
  parameter int                  COLSPC     = 10,
  parameter logic [COLSPC-1:0]   TRANSP_KEY = '0,
  parameter logic [3*COLSPC-1:0] BG_COLOR   = '0
) (
  input  logic                      video_clk_pix,
  input  logic                      video_rst,
  video_layer_compositor_if.slave   bus
);
  localparam int                  CW   = 3 * COLSPC;
  localparam logic [CW-1:0]       KEY3 = {3{TRANSP_KEY}};
`ifdef VIDEO_COMPOSITOR_BLEND_EN
  localparam int                  EW   = CW + 2;
`else
  localparam int                  EW   = CW + 1;
`endif

`ifdef VIDEO_COMPOSITOR_BLEND_EN
  function automatic logic [CW-1:0] blend_rgb(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic [COLSPC:0] sum;
    logic [CW-1:0]   res;
    res = '0;
    for (int c = 0; c < 3; c++) begin
      sum = {1'b0, a[c*COLSPC +: COLSPC]} + {1'b0, b[c*COLSPC +: COLSPC]};
      res[c*COLSPC +: COLSPC] = sum[COLSPC:1];
    end
    return res;
  endfunction
`endif

  logic [NUM_LAYERS-1:0] en_shadow_r;
  logic [NUM_LAYERS-1:0] en_eff_s;
  logic [CW-1:0]         acc_r  [NUM_LAYERS];
  logic [CW-1:0]         next_s [NUM_LAYERS];
  logic [4:0]            sync_r [NUM_LAYERS];

  logic [COORDSPC-1:0]   unused_coord_s;
  assign unused_coord_s = bus.sx ^ bus.sy;
`ifndef VIDEO_COMPOSITOR_BLEND_EN
  logic [NUM_LAYERS-1:0] unused_blend_s;
  assign unused_blend_s = bus.layer_blend;
`endif

  // Mask in force for the entering pixel; the frame_start pixel already sees the new mask.
  always_comb begin
    if (bus.frame_start) begin
      en_eff_s = bus.layer_en;
    end else begin
      en_eff_s = en_shadow_r;
    end
  end

  // Enable shadow, reloaded only on frame_start so a frame never tears.
  always_ff @(posedge video_clk_pix) begin
    if (video_rst) begin
      en_shadow_r <= '1;
    end else if (bus.frame_start) begin
      en_shadow_r <= bus.layer_en;
    end else begin
      en_shadow_r <= en_shadow_r;
    end
  end

  for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_layer
    logic [CW-1:0] rgb_s;
    logic [CW-1:0] prev_s;
    logic          opq_s;
    logic [EW-1:0] ent_s;
    logic [EW-1:0] tap_s;

    assign rgb_s = {bus.layer_red[k*COLSPC +: COLSPC],
                    bus.layer_green[k*COLSPC +: COLSPC],
                    bus.layer_blue[k*COLSPC +: COLSPC]};
    // Opacity folds in blanking, so a blanked pixel leaves every layer transparent.
    assign opq_s = bus.video_enable && en_eff_s[k] && (rgb_s != KEY3);
`ifdef VIDEO_COMPOSITOR_BLEND_EN
    assign ent_s = {((k == 0) ? 1'b0 : bus.layer_blend[k]), opq_s, rgb_s};
`else
    assign ent_s = {opq_s, rgb_s};
`endif

    if (k == 0) begin : g_base
      assign tap_s  = ent_s;
      assign prev_s = bus.video_enable ? BG_COLOR : {CW{1'b0}};
    end else begin : g_stack
      logic [EW-1:0] dly_r [k];

      // Layer k waits k cycles so it meets the accumulator of layer k-1 for the same pixel.
      always_ff @(posedge video_clk_pix) begin
        if (video_rst) begin
          for (int j = 0; j < k; j++) begin
            dly_r[j] <= '0;
          end
        end else begin
          dly_r[0] <= ent_s;
          for (int j = 1; j < k; j++) begin
            dly_r[j] <= dly_r[j-1];
          end
        end
      end

      assign tap_s  = dly_r[k-1];
      assign prev_s = acc_r[k-1];
    end

`ifdef VIDEO_COMPOSITOR_BLEND_EN
    assign next_s[k] = !tap_s[CW] ? prev_s :
                       (tap_s[CW+1] ? blend_rgb(tap_s[CW-1:0], prev_s) : tap_s[CW-1:0]);
`else
    assign next_s[k] = tap_s[CW] ? tap_s[CW-1:0] : prev_s;
`endif
  end

  // Composition accumulators, bottom layer first; the last one is the output pixel.
  always_ff @(posedge video_clk_pix) begin
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (video_rst) begin
        acc_r[k] <= '0;
      end else begin
        acc_r[k] <= next_s[k];
      end
    end
  end

  // Timing signals ride a LAT-deep shift register alongside the pixels.
  always_ff @(posedge video_clk_pix) begin
    if (video_rst) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        sync_r[i] <= 5'b00000;
      end
    end else begin
      sync_r[0] <= {bus.video_enable, bus.vsync, bus.hsync, bus.frame_start, bus.line_start};
      for (int i = 1; i < NUM_LAYERS; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  assign bus.red             = acc_r[NUM_LAYERS-1][2*COLSPC +: COLSPC];
  assign bus.green           = acc_r[NUM_LAYERS-1][COLSPC +: COLSPC];
  assign bus.blue            = acc_r[NUM_LAYERS-1][0 +: COLSPC];
  assign bus.out_de          = sync_r[NUM_LAYERS-1][4];
  assign bus.out_vsync       = sync_r[NUM_LAYERS-1][3];
  assign bus.out_hsync       = sync_r[NUM_LAYERS-1][2];
  assign bus.out_frame_start = sync_r[NUM_LAYERS-1][1];
  assign bus.out_line_start  = sync_r[NUM_LAYERS-1][0];
endmodule
